// File: rtl/dual_grant_lane_router_if.sv
// -----------------------------------------------------------------------------
// dual_grant_lane_router_if
//
// Bundles the arbiter grant, the four requester source streams, the two
// output lanes and the sticky error flags of dual_grant_lane_router.
//
//   grant[3:0]          arbiter grant vector (up to two bits expected)
//   src_valid[3:0]      per-requester beat valid
//   src_data[4*DW-1:0]  requester i data on [i*DW +: DW]
//   src_last[3:0]       per-requester last beat of burst
//   src_ready[3:0]      per-requester pop strobe
//   laneN_valid/data/id/last  registered lane beat
//   laneN_ready         downstream accepts the lane beat
//   err[1:0]            sticky: [0] >2 grants seen, [1] grant lost mid-burst
//
// modport master : the side that owns the requesters and lane consumers
// modport slave  : the router itself
// -----------------------------------------------------------------------------
interface dual_grant_lane_router_if #(
    parameter int DW = 32
);
    logic [3:0]      grant;
    logic [3:0]      src_valid;
    logic [4*DW-1:0] src_data;
    logic [3:0]      src_last;
    logic [3:0]      src_ready;

    logic            lane0_valid;
    logic [DW-1:0]   lane0_data;
    logic [1:0]      lane0_id;
    logic            lane0_last;
    logic            lane0_ready;

    logic            lane1_valid;
    logic [DW-1:0]   lane1_data;
    logic [1:0]      lane1_id;
    logic            lane1_last;
    logic            lane1_ready;

    logic [1:0]      err;

    modport master (
        output grant, src_valid, src_data, src_last,
        output lane0_ready, lane1_ready,
        input  src_ready,
        input  lane0_valid, lane0_data, lane0_id, lane0_last,
        input  lane1_valid, lane1_data, lane1_id, lane1_last,
        input  err
    );

    modport slave (
        input  grant, src_valid, src_data, src_last,
        input  lane0_ready, lane1_ready,
        output src_ready,
        output lane0_valid, lane0_data, lane0_id, lane0_last,
        output lane1_valid, lane1_data, lane1_id, lane1_last,
        output err
    );
endinterface

// File: rtl/dual_grant_lane_router.sv
// -----------------------------------------------------------------------------
// dual_grant_lane_router
//
// Binds up to two granted requesters to two output lanes and moves their
// bursts through a one-deep registered valid/ready stage per lane. A lane
// stays bound until a last beat is transferred (explicit src_last or the
// MAX_BEATS cap) or until the grant of its bound requester is withdrawn.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   dual_grant_lane_router_if.slave (grant, sources, lanes, err)
//
// Parameters:
//   DW         data width per requester and per lane
//   MAX_BEATS  burst length cap (2..256); beat counter is $clog2 wide
// -----------------------------------------------------------------------------
module dual_grant_lane_router #(
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    dual_grant_lane_router_if.slave  bus
);

    localparam int            CW       = $clog2(MAX_BEATS);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

    typedef enum logic {
        FREE  = 1'b0,
        BOUND = 1'b1
    } lane_state_e;

    // Registered lane state, index 0 = lane0, 1 = lane1
    lane_state_e   state_q  [2];
    logic [1:0]    bid_q    [2];
    logic [CW-1:0] cnt_q    [2];
    logic          ovalid_q [2];
    logic [DW-1:0] odata_q  [2];
    logic [1:0]    oid_q    [2];
    logic          olast_q  [2];
    logic [1:0]    err_q;

    // Binding decision
    logic [3:0]    bound_mask;
    logic [3:0]    cand;
    logic          first_ok;
    logic          second_ok;
    logic [1:0]    first_id;
    logic [1:0]    second_id;
    logic [1:0]    bind_en;
    logic [1:0]    bind_id  [2];

    // Per-lane handshake
    logic [1:0]    lane_ready;
    logic [1:0]    push_ok;
    logic [1:0]    xfer;
    logic [1:0]    beat_last;
    logic [1:0]    drop;
    logic [DW-1:0] beat_data [2];
    logic [3:0]    src_ready;

    assign lane_ready = {bus.lane1_ready, bus.lane0_ready};

    // -------------------------------------------------------------------------
    // Binding: candidates are granted requesters not already held by a lane.
    // Decided purely from registered lane state, so a lane freed this cycle
    // is only eligible next cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned and no latch is inferred.
        bound_mask = '0;
        first_ok   = 1'b0;
        second_ok  = 1'b0;
        first_id   = '0;
        second_id  = '0;
        bind_en    = '0;
        bind_id[0] = '0;
        bind_id[1] = '0;

        for (int l = 0; l < 2; l++) begin
            if (state_q[l] == BOUND) begin
                bound_mask[bid_q[l]] = 1'b1;
            end
        end
        cand = bus.grant & ~bound_mask;

        // Lowest and next-lowest candidate; any grant bits beyond those two
        // are ignored (and flagged via err[0]).
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                if (!first_ok) begin
                    first_ok = 1'b1;
                    first_id = 2'(i);
                end else if (!second_ok) begin
                    second_ok = 1'b1;
                    second_id = 2'(i);
                end
            end
        end

        if (state_q[0] == FREE && state_q[1] == FREE) begin
            bind_en[0] = first_ok;
            bind_id[0] = first_id;
            bind_en[1] = second_ok;
            bind_id[1] = second_id;
        end else if (state_q[0] == FREE) begin
            bind_en[0] = first_ok;
            bind_id[0] = first_id;
        end else if (state_q[1] == FREE) begin
            bind_en[1] = first_ok;
            bind_id[1] = first_id;
        end
    end

    // -------------------------------------------------------------------------
    // Lane handshake. push_ok has no dependency on src_valid, which keeps
    // src_ready free of any path from src_valid.
    // -------------------------------------------------------------------------
    always_comb begin
        push_ok      = '0;
        xfer         = '0;
        beat_last    = '0;
        drop         = '0;
        beat_data[0] = '0;
        beat_data[1] = '0;
        src_ready    = '0;

        for (int l = 0; l < 2; l++) begin
            push_ok[l]   = (state_q[l] == BOUND) && bus.grant[bid_q[l]] &&
                           (!ovalid_q[l] || lane_ready[l]);
            xfer[l]      = push_ok[l] && bus.src_valid[bid_q[l]];
            // The cap forces a burst end even if the source never says last.
            beat_last[l] = bus.src_last[bid_q[l]] || (cnt_q[l] == CNT_LAST);
            drop[l]      = (state_q[l] == BOUND) && !bus.grant[bid_q[l]];
            beat_data[l] = bus.src_data[int'(bid_q[l]) * DW +: DW];
        end

        for (int i = 0; i < 4; i++) begin
            src_ready[i] = (push_ok[0] && bid_q[0] == 2'(i)) ||
                           (push_ok[1] && bid_q[1] == 2'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Lane FSMs, lane output registers and sticky errors.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the lane data/id registers are reset as well, because the
            // lane outputs must read zero immediately on reset.
            for (int l = 0; l < 2; l++) begin
                state_q[l]  <= FREE;
                bid_q[l]    <= '0;
                cnt_q[l]    <= '0;
                ovalid_q[l] <= 1'b0;
                odata_q[l]  <= '0;
                oid_q[l]    <= '0;
                olast_q[l]  <= 1'b0;
            end
            err_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // read in this block sees the value from before the clock edge.
            for (int l = 0; l < 2; l++) begin
                case (state_q[l])
                    FREE: begin
                        if (bind_en[l]) begin
                            state_q[l] <= BOUND;
                            bid_q[l]   <= bind_id[l];
                            cnt_q[l]   <= '0;
                        end
                    end
                    BOUND: begin
                        if (xfer[l]) begin
                            cnt_q[l] <= (cnt_q[l] == CNT_LAST) ? '0 : cnt_q[l] + 1'b1;
                        end
                        if ((xfer[l] && beat_last[l]) || drop[l]) begin
                            state_q[l] <= FREE;
                        end
                    end
                    default: state_q[l] <= FREE;
                endcase

                // One-deep output stage: load on transfer, drain on ready.
                // A registered beat survives unbind or grant loss.
                if (xfer[l]) begin
                    ovalid_q[l] <= 1'b1;
                    odata_q[l]  <= beat_data[l];
                    oid_q[l]    <= bid_q[l];
                    olast_q[l]  <= beat_last[l];
                end else if (lane_ready[l]) begin
                    ovalid_q[l] <= 1'b0;
                end
            end

            if ($countones(bus.grant) > 2) begin
                err_q[0] <= 1'b1;
            end
            // A last-beat transfer coinciding with the withdrawal is a
            // normal end, not an error.
            if ((drop[0] && !(xfer[0] && beat_last[0])) ||
                (drop[1] && !(xfer[1] && beat_last[1]))) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.src_ready   = src_ready;
    assign bus.lane0_valid = ovalid_q[0];
    assign bus.lane0_data  = odata_q[0];
    assign bus.lane0_id    = oid_q[0];
    assign bus.lane0_last  = olast_q[0];
    assign bus.lane1_valid = ovalid_q[1];
    assign bus.lane1_data  = odata_q[1];
    assign bus.lane1_id    = oid_q[1];
    assign bus.lane1_last  = olast_q[1];
    assign bus.err         = err_q;

endmodule
